secp256k1_point_serializer: RTL and testbench

Transmit-side adapter on the output of the secp256k1 point multiplier. It accepts one full-width Jacobian point (768 bits: x, y, z) per valid/ready handshake and sends it as a packet of narrow AXI-stream beats with sop, eop, mod and err. It feeds the host/PCIe stream interface, and it is the counterpart of the stream-to-point loading used on the multiplier input.

---
 rtl/secp256k1_point_serializer.sv | 91 +++++++++
 tb/tb_secp256k1_point_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/secp256k1_point_serializer.sv
// rtl/secp256k1_point_serializer.sv - Jacobian point to sop/eop beat stream serializer
module secp256k1_point_serializer #(
  parameter int DAT_BITS = 64,
  parameter int BEATS    = 768 / DAT_BITS,
  parameter int MOD_BITS = $clog2(DAT_BITS / 8)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [767:0]        i_p,
  input  logic                i_err,
  input  logic                i_val,
  output logic                o_rdy,
  output logic [DAT_BITS-1:0] o_dat,
  output logic                o_val,
  input  logic                i_rdy,
  output logic                o_sop,
  output logic                o_eop,
  output logic [MOD_BITS-1:0] o_mod,
  output logic                o_err
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state, state_n;
  logic [CNT_W-1:0]             cnt, cnt_n;
  logic [BEATS-1:0][DAT_BITS-1:0] hold;
  logic                         err_q;
  logic                         last;
  logic                         accept;

  assign last = (cnt == LAST);

  // Ready is also offered on the eop transfer so packets can run back to back.
  assign o_rdy  = i_rst & ((state == IDLE) | ((state == SEND) & last & i_rdy));
  assign accept = i_val & o_rdy;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        hold  <= i_p;
        err_q <= i_err;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SEND;
          cnt_n   = '0;
        end
      end
      SEND: begin
        if (i_rdy) begin
          if (last) begin
            cnt_n = '0;
            if (!accept) state_n = IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign o_val = (state == SEND);
  assign o_dat = o_val ? hold[cnt] : '0;
  assign o_sop = o_val & (cnt == '0);
  assign o_eop = o_val & last;
  assign o_err = o_val & err_q;
  assign o_mod = '0;

endmodule

// File: tb/tb_secp256k1_point_serializer.sv
// tb/tb_secp256k1_point_serializer.sv - directed bench for secp256k1_point_serializer
module tb_secp256k1_point_serializer;

  localparam logic [255:0] GX  = 256'h79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28d959f2815b16f81798;
  localparam logic [255:0] GY  = 256'h483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8;
  localparam logic [255:0] X2  = 256'hc6047f9441ed7d6d3045406e95c07cd85c778e4b8cef3ca7abac09b95c709ee5;
  localparam logic [255:0] Y2  = 256'h1ae168fea63dc339a3c58419466ceaeef7f632653266d0e1236431a950cfe52a;
  localparam logic [255:0] X3  = 256'hf9308a019258c31049344f85f89d5229b531c845836f99b08601f113bce036f9;
  localparam logic [255:0] Y3  = 256'h388f7b0f632de8140fe337e62a37f3566500a99934c2231b6cb9fd7584b8e672;
  localparam logic [255:0] Z3  = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a6978388fa11ff621a970;
  localparam logic [767:0] GPT = {GX, GY, 256'h1};
  localparam logic [767:0] P2  = {X2, Y2, 256'h2};
  localparam logic [767:0] P3  = {X3, Y3, Z3};
  localparam logic [767:0] PB  = {96{8'h11}};

  logic         clk, rst;
  logic [767:0] p;
  logic         err, val, rdy;
  logic         o_rdy, o_val, o_sop, o_eop, o_err;
  logic [63:0]  o_dat;
  logic [2:0]   o_mod;

  logic [767:0] p2;
  logic         err2, val2, rdy2;
  logic         o_rdy2, o_val2, o_sop2, o_eop2, o_err2;
  logic [255:0] o_dat2;
  logic [4:0]   o_mod2;

  int           n_chk, n_fail;
  logic [63:0]  beats [0:23];

  secp256k1_point_serializer #(.DAT_BITS(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_p(p), .i_err(err), .i_val(val), .o_rdy(o_rdy),
    .o_dat(o_dat), .o_val(o_val), .i_rdy(rdy), .o_sop(o_sop), .o_eop(o_eop),
    .o_mod(o_mod), .o_err(o_err)
  );

  secp256k1_point_serializer #(.DAT_BITS(256)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_p(p2), .i_err(err2), .i_val(val2), .o_rdy(o_rdy2),
    .o_dat(o_dat2), .o_val(o_val2), .i_rdy(rdy2), .o_sop(o_sop2), .o_eop(o_eop2),
    .o_mod(o_mod2), .o_err(o_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_one(input logic [767:0] pt, input logic e);
    @(negedge clk);
    p = pt; err = e; val = 1'b1; rdy = 1'b1;
    #1 chk1("idle_rdy", o_rdy, 1'b1);
    @(posedge clk);
    #1 val = 1'b0; p = '0;
    for (int b = 0; b < 12; b++) begin
      @(negedge clk);
      beats[b] = o_dat;
      chk1($sformatf("s_val%0d", b), o_val, 1'b1);
      chkv($sformatf("s_dat%0d", b), 768'(o_dat), 768'(pt[b*64 +: 64]));
      chk1($sformatf("s_sop%0d", b), o_sop, b == 0);
      chk1($sformatf("s_eop%0d", b), o_eop, b == 11);
      chk1($sformatf("s_err%0d", b), o_err, e);
      chk1($sformatf("s_rdy%0d", b), o_rdy, b == 11);
      chkv($sformatf("s_mod%0d", b), 768'(o_mod), 768'(0));
    end
    @(negedge clk);
    chk1("s_idle_val", o_val, 1'b0);
  endtask

  task automatic send_two(input logic [767:0] pa, input logic ea,
                          input logic [767:0] pb, input logic eb);
    logic [63:0] exp;
    @(negedge clk);
    p = pa; err = ea; val = 1'b1; rdy = 1'b1;
    @(posedge clk);
    #1 p = pb; err = eb;
    for (int b = 0; b < 24; b++) begin
      @(negedge clk);
      if (b == 12) begin
        val = 1'b0; p = '0;
        #1;
      end
      beats[b] = o_dat;
      exp = (b < 12) ? pa[b*64 +: 64] : pb[(b-12)*64 +: 64];
      chk1($sformatf("b2b_val%0d", b), o_val, 1'b1);
      chkv($sformatf("b2b_dat%0d", b), 768'(o_dat), 768'(exp));
      chk1($sformatf("b2b_sop%0d", b), o_sop, (b % 12) == 0);
      chk1($sformatf("b2b_eop%0d", b), o_eop, (b % 12) == 11);
      chk1($sformatf("b2b_err%0d", b), o_err, (b < 12) ? ea : eb);
      if (b == 11) chk1("b2b_rdy_last", o_rdy, 1'b1);
    end
    @(negedge clk);
    chk1("b2b_idle_val", o_val, 1'b0);
  endtask

  initial begin
    logic [767:0] asm_pt;
    logic [63:0]  prev_dat;
    logic         prev_sop, prev_eop, stall;
    int           got, cyc;
    logic [255:0] exp_w;

    n_chk = 0; n_fail = 0;
    rst = 1'b0; p = '0; err = 1'b0; val = 1'b0; rdy = 1'b0;
    p2 = '0; err2 = 1'b0; val2 = 1'b0; rdy2 = 1'b0;

    #2;
    chk1("rst_val", o_val, 1'b0);
    chk1("rst_sop", o_sop, 1'b0);
    chk1("rst_eop", o_eop, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    chk1("rst_rdy", o_rdy, 1'b0);
    chkv("rst_dat", 768'(o_dat), 768'(0));
    chkv("rst_mod", 768'(o_mod), 768'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    send_one(GPT, 1'b0);
    chkv("g_beat0", 768'(beats[0]), 768'(64'h0000000000000001));
    chkv("g_beat1", 768'(beats[1]), 768'(64'h0));
    chkv("g_beat4", 768'(beats[4]), 768'(64'h9c47d08ffb10d4b8));
    chkv("g_beat11", 768'(beats[11]), 768'(64'h79be667ef9dcbbac));

    @(negedge clk);
    p = PB; err = 1'b0; val = 1'b1; rdy = 1'b1;
    @(posedge clk);
    #1 val = 1'b0; p = '0;
    got = 0; cyc = 0; stall = 1'b0; asm_pt = '0;
    prev_dat = '0; prev_sop = 1'b0; prev_eop = 1'b0;
    while (got < 12 && cyc < 400) begin
      @(negedge clk);
      rdy = 1'($urandom_range(0, 1));
      #1;
      chk1("bp_val", o_val, 1'b1);
      chk1("bp_sop", o_sop, got == 0);
      chk1("bp_eop", o_eop, got == 11);
      if (stall) begin
        chkv("bp_hold_dat", 768'(o_dat), 768'(prev_dat));
        chk1("bp_hold_sop", o_sop, prev_sop);
        chk1("bp_hold_eop", o_eop, prev_eop);
      end
      prev_dat = o_dat; prev_sop = o_sop; prev_eop = o_eop;
      stall = o_val & ~rdy;
      if (o_val & rdy) begin
        asm_pt[got*64 +: 64] = o_dat;
        got++;
      end
      cyc++;
    end
    chk1("bp_done", got == 12, 1'b1);
    chkv("bp_reassembled", asm_pt, PB);
    rdy = 1'b1;
    @(negedge clk);
    chk1("bp_idle_val", o_val, 1'b0);

    send_two(P2, 1'b0, P3, 1'b0);
    chkv("b2b_beat12", 768'(beats[12]), 768'(64'h388fa11ff621a970));
    chkv("b2b_beat11", 768'(beats[11]), 768'(X2[255:192]));

    send_two(GPT, 1'b1, P2, 1'b0);

    @(negedge clk);
    p = GPT; err = 1'b1; val = 1'b1; rdy = 1'b1;
    @(posedge clk);
    #1 val = 1'b0; p = '0;
    repeat (6) @(negedge clk);
    chk1("mid_val_before", o_val, 1'b1);
    chk1("mid_err_before", o_err, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("mid_rst_val", o_val, 1'b0);
    chk1("mid_rst_sop", o_sop, 1'b0);
    chk1("mid_rst_eop", o_eop, 1'b0);
    chk1("mid_rst_err", o_err, 1'b0);
    chk1("mid_rst_rdy", o_rdy, 1'b0);
    @(negedge clk);
    chk1("mid_rst_rdy_held", o_rdy, 1'b0);
    rst = 1'b1;
    #1;
    chk1("mid_rel_rdy", o_rdy, 1'b1);
    chk1("mid_rel_val", o_val, 1'b0);
    send_one(GPT, 1'b0);
    chkv("mid_new_beat0", 768'(beats[0]), 768'(64'h1));

    @(negedge clk);
    p2 = GPT; err2 = 1'b0; val2 = 1'b1; rdy2 = 1'b1;
    @(posedge clk);
    #1 val2 = 1'b0; p2 = '0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      exp_w = (b == 0) ? 256'h1 : (b == 1) ? GY : GX;
      chk1($sformatf("w_val%0d", b), o_val2, 1'b1);
      chkv($sformatf("w_dat%0d", b), 768'(o_dat2), 768'(exp_w));
      chk1($sformatf("w_sop%0d", b), o_sop2, b == 0);
      chk1($sformatf("w_eop%0d", b), o_eop2, b == 2);
      chk1($sformatf("w_err%0d", b), o_err2, 1'b0);
      chkv($sformatf("w_mod%0d", b), 768'(o_mod2), 768'(0));
    end
    @(negedge clk);
    chk1("w_idle_val", o_val2, 1'b0);
    chk1("w_idle_rdy", o_rdy2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
